win_check_sequencer: RTL

//  Sequencer that evaluates the 3x3 tic-tac-toe board for win/tie on request from the game FSM.

---
 rtl/tictactoe_pkg.sv | 34 +++
 rtl/win_check_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe win/tie checking logic.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        PX    = 2'b01,
        PO    = 2'b10,
        INV   = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        CHECK,
        DONE
    } wcs_state_t;

    localparam int N_CELLS = 9;
    localparam int N_LINES = 8;

    // Cell indices (row*3+col) of the 8 scoring lines: rows, columns, diagonals.
    localparam logic [3:0] LINES [N_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/win_check_sequencer.sv
// Reads the 9 board cells through a synchronous read port, then scans the
// 8 lines one per cycle and reports win/tie with a fixed latency.
module win_check_sequencer
    import tictactoe_pkg::*;
#(
    parameter int CELL_W = 2,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CELL_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              win,
    output logic              tie,
    output logic [CELL_W-1:0] winner,
    output logic [2:0]        win_line
);

    localparam logic [CELL_W-1:0] CELL_X = CELL_W'(PX);
    localparam logic [CELL_W-1:0] CELL_O = CELL_W'(PO);

    wcs_state_t state_q, state_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic [2:0]        line_idx_q, line_idx_d;
    logic [CELL_W-1:0] cells_q [N_CELLS];
    logic [CELL_W-1:0] cells_d [N_CELLS];

    // Shift pipe tracking which address is returning on rd_data this cycle.
    logic [RD_LAT-1:0]             pvld_q, pvld_d;
    logic [RD_LAT-1:0][ADDR_W-1:0] paddr_q, paddr_d;

    logic              win_q, win_d;
    logic              tie_q, tie_d;
    logic [CELL_W-1:0] winner_q, winner_d;
    logic [2:0]        win_line_q, win_line_d;

    logic [CELL_W-1:0] ca, cb, cc;
    logic              line_hit;
    logic              board_full;

    assign rd_en    = (state_q == LOAD);
    assign rd_addr  = rd_idx_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign win      = win_q;
    assign tie      = tie_q;
    assign winner   = winner_q;
    assign win_line = win_line_q;

    // Line evaluation for the current line index and board-full detection.
    always_comb begin
        ca         = cells_q[LINES[line_idx_q][0]];
        cb         = cells_q[LINES[line_idx_q][1]];
        cc         = cells_q[LINES[line_idx_q][2]];
        line_hit   = (ca == cb) && (cb == cc) && ((ca == CELL_X) || (ca == CELL_O));
        board_full = 1'b1;
        for (int i = 0; i < N_CELLS; i++) begin
            if ((cells_q[i] != CELL_X) && (cells_q[i] != CELL_O)) begin
                board_full = 1'b0;
            end
        end
    end

    // Next-state, read pipe, cell capture and result computation.
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        flush_cnt_d = flush_cnt_q;
        line_idx_d  = line_idx_q;
        win_d       = win_q;
        tie_d       = tie_q;
        winner_d    = winner_q;
        win_line_d  = win_line_q;
        cells_d     = cells_q;

        pvld_d[0]  = rd_en;
        paddr_d[0] = rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pvld_d[i]  = pvld_q[i-1];
            paddr_d[i] = paddr_q[i-1];
        end

        // Data for the address issued RD_LAT cycles ago is on rd_data now.
        if (pvld_q[RD_LAT-1]) begin
            cells_d[paddr_q[RD_LAT-1]] = rd_data;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    rd_idx_d   = '0;
                    win_d      = 1'b0;
                    tie_d      = 1'b0;
                    winner_d   = '0;
                    win_line_d = '0;
                end
            end
            LOAD: begin
                if (rd_idx_q == ADDR_W'(N_CELLS - 1)) begin
                    state_d     = FLUSH;
                    rd_idx_d    = '0;
                    flush_cnt_d = '0;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 2'(RD_LAT - 1)) begin
                    state_d    = CHECK;
                    line_idx_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                // Only the lowest-index matching line is reported.
                if (line_hit && !win_q) begin
                    win_d      = 1'b1;
                    winner_d   = ca;
                    win_line_d = line_idx_q;
                end
                if (line_idx_q == 3'(N_LINES - 1)) begin
                    state_d    = DONE;
                    line_idx_d = '0;
                    tie_d      = !win_d && board_full;
                end else begin
                    line_idx_d = line_idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_idx_q    <= '0;
            flush_cnt_q <= '0;
            line_idx_q  <= '0;
            pvld_q      <= '0;
            paddr_q     <= '0;
            win_q       <= 1'b0;
            tie_q       <= 1'b0;
            winner_q    <= '0;
            win_line_q  <= '0;
            for (int i = 0; i < N_CELLS; i++) begin
                cells_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            flush_cnt_q <= flush_cnt_d;
            line_idx_q  <= line_idx_d;
            pvld_q      <= pvld_d;
            paddr_q     <= paddr_d;
            win_q       <= win_d;
            tie_q       <= tie_d;
            winner_q    <= winner_d;
            win_line_q  <= win_line_d;
            for (int i = 0; i < N_CELLS; i++) begin
                cells_q[i] <= cells_d[i];
            end
        end
    end

endmodule
